// File: rtl/keypad_lock_pkg.sv
// Shared definitions for the keypad lock controller.
//  - state_e  : controller FSM encoding (also driven out on state_out)
//  - KEY_*    : key codes with special meaning
//  - keymap() : (column, row) position on the 4x4 matrix -> key code
package keypad_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROGRAM = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;

  // Column-major layout: c0=1,4,7,0  c1=2,5,8,F  c2=3,6,9,E  c3=A,B,C,D
  function automatic logic [3:0] keymap(input logic [1:0] col, input logic [1:0] row);
    case ({col, row})
      4'h0: keymap = 4'h1;  4'h1: keymap = 4'h4;  4'h2: keymap = 4'h7;  4'h3: keymap = 4'h0;
      4'h4: keymap = 4'h2;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h8;  4'h7: keymap = 4'hF;
      4'h8: keymap = 4'h3;  4'h9: keymap = 4'h6;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hE;
      4'hC: keymap = 4'hA;  4'hD: keymap = 4'hB;  4'hE: keymap = 4'hC;  default: keymap = 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Pin/status bundle of the keypad lock controller.
//  row_n, lock_btn, prog_btn : board inputs (driven by master)
//  col_n                     : column drive to the keypad
//  key_valid, key_code       : accepted-key pulse and last key
//  digit_count, unlocked, lockout, fail_count, state_out : status for LEDs / 7-seg
interface keypad_lock_ctrl_if;
  logic [3:0] row_n;
  logic       lock_btn;
  logic       prog_btn;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] digit_count;
  logic       unlocked;
  logic       lockout;
  logic [3:0] fail_count;
  logic [2:0] state_out;

  modport master (output row_n, lock_btn, prog_btn,
                  input  col_n, key_valid, key_code, digit_count, unlocked, lockout,
                         fail_count, state_out);
  modport slave  (input  row_n, lock_btn, prog_btn,
                  output col_n, key_valid, key_code, digit_count, unlocked, lockout,
                         fail_count, state_out);
endinterface

// File: rtl/keypad_lock_ctrl_scan.sv
// keypad_scan: drives one keypad column low at a time, samples the synchronised
// rows at the end of each column slot, reduces a full 4-column scan to
// "exactly one key" or "none", and debounces that result.
//  clk, reset          : clock, async active-high reset
//  row_n               : raw keypad rows (asynchronous)
//  col_n               : one-hot-low column drive
//  key_valid, key_code : one-cycle accept pulse, last accepted key (holds)
module keypad_scan
  import keypad_lock_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int TW = $clog2(SCAN_TICKS + 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    row_s1_q, row_s2_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    acc_n_q, acc_n_d;     // lows seen so far this scan, saturates at 2
  logic [3:0]    acc_code_q, acc_code_d;
  logic          cand_vld_q, cand_vld_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [DW-1:0] same_q, same_d;       // consecutive identical scan results
  logic          armed_q, armed_d;     // cleared after accept, set after enough "none" scans
  logic          kv_q, kv_d;
  logic [3:0]    kc_q, kc_d;

  logic [2:0]    low_n, sum;
  logic [1:0]    low_row, n_tot;
  logic [3:0]    code;
  logic          res_vld;
  logic [3:0]    res_code;
  logic [DW-1:0] same_n;

  always_comb begin
    tick_d      = tick_q + TW'(1);
    col_d       = col_q;
    acc_n_d     = acc_n_q;
    acc_code_d  = acc_code_q;
    cand_vld_d  = cand_vld_q;
    cand_code_d = cand_code_q;
    same_d      = same_q;
    armed_d     = armed_q;
    kv_d        = 1'b0;
    kc_d        = kc_q;
    low_n       = 3'd0;
    low_row     = 2'd0;
    n_tot       = 2'd0;
    code        = acc_code_q;
    res_vld     = 1'b0;
    res_code    = 4'h0;
    same_n      = same_q;

    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        low_n   = low_n + 3'd1;
        low_row = r[1:0];
      end
    end
    sum   = {1'b0, acc_n_q} + low_n;
    n_tot = (sum > 3'd1) ? 2'd2 : sum[1:0];
    if (acc_n_q == 2'd0 && low_n == 3'd1) code = keymap(col_q, low_row);

    if (tick_q == TW'(SCAN_TICKS - 1)) begin
      tick_d = '0;
      col_d  = col_q + 2'd1;
      if (col_q != 2'd3) begin
        acc_n_d    = n_tot;
        acc_code_d = code;
      end else begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'h0;
        res_vld    = (n_tot == 2'd1);
        res_code   = res_vld ? code : 4'h0;
        if (res_vld == cand_vld_q && res_code == cand_code_q)
          same_n = (same_q == DW'(DEBOUNCE_SCANS)) ? same_q : same_q + DW'(1);
        else begin
          cand_vld_d  = res_vld;
          cand_code_d = res_code;
          same_n      = DW'(1);
        end
        same_d = same_n;
        if (same_n == DW'(DEBOUNCE_SCANS)) begin
          if (armed_q && res_vld) begin
            armed_d = 1'b0;
            kv_d    = 1'b1;
            kc_d    = res_code;
          end else if (!armed_q && !res_vld) begin
            armed_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      tick_q      <= '0;
      col_q       <= 2'd0;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'h0;
      cand_vld_q  <= 1'b0;
      cand_code_q <= 4'h0;
      same_q      <= '0;
      armed_q     <= 1'b1;
      kv_q        <= 1'b0;
      kc_q        <= 4'h0;
    end else begin
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      tick_q      <= tick_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      cand_vld_q  <= cand_vld_d;
      cand_code_q <= cand_code_d;
      same_q      <= same_d;
      armed_q     <= armed_d;
      kv_q        <= kv_d;
      kc_q        <= kc_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_valid = kv_q;
  assign key_code  = kc_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: keypad code lock. Collects CODE_LEN digits, compares them
// with a programmable code, counts consecutive failures with a timed lockout,
// and allows re-programming the code while open.
//  clk, reset : clock, async active-high reset
//  bus        : keypad pins, buttons and status outputs (keypad_lock_ctrl_if.slave)
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int                  SCAN_TICKS     = 100000,
  parameter int                  DEBOUNCE_SCANS = 3,
  parameter int                  CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1111,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_TICKS  = 300000000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_lock_ctrl_if.slave  bus
);
  localparam int CW = 4 * CODE_LEN;
  localparam int LW = $clog2(LOCKOUT_TICKS + 1);

  logic       kv;
  logic [3:0] kc;

  keypad_scan #(.SCAN_TICKS(SCAN_TICKS), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .row_n     (bus.row_n),
    .col_n     (bus.col_n),
    .key_valid (kv),
    .key_code  (kc)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] entry_q, entry_d, code_q, code_d;
  logic [3:0]    dcnt_q, dcnt_d, fail_q, fail_d;
  logic [LW-1:0] lo_tmr_q, lo_tmr_d;
  logic [2:0]    lock_s_q, prog_s_q;   // [0],[1] synchroniser, [2] previous for edge detect

  logic          lock_edge, prog_edge, digit, clr;
  logic [CW-1:0] key_ext, entry_shift;
  logic [3:0]    fail_inc;

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    code_d   = code_q;
    dcnt_d   = dcnt_q;
    fail_d   = fail_q;
    lo_tmr_d = lo_tmr_q;
    lock_edge = lock_s_q[1] & ~lock_s_q[2];
    prog_edge = prog_s_q[1] & ~prog_s_q[2];
    digit     = kv && (kc <= KEY_MAX_DIGIT);
    clr       = kv && (kc == KEY_CLEAR);
    key_ext   = '0;
    key_ext[3:0] = kc;
    entry_shift  = (entry_q << 4) | key_ext;
    fail_inc     = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;

    case (state_q)
      ST_LOCKED, ST_PROGRAM: begin
        if (state_q == ST_PROGRAM && lock_edge) begin
          // abort programming; stored code untouched
          state_d = ST_LOCKED;
          entry_d = '0;
          dcnt_d  = 4'd0;
        end else if (clr) begin
          entry_d = '0;
          dcnt_d  = 4'd0;
        end else if (digit) begin
          entry_d = entry_shift;
          dcnt_d  = dcnt_q + 4'd1;
          if (dcnt_q == 4'(CODE_LEN - 1)) begin
            if (state_q == ST_LOCKED) state_d = ST_CHECK;
            else begin
              code_d  = entry_shift;
              entry_d = '0;
              dcnt_d  = 4'd0;
              state_d = ST_OPEN;
            end
          end
        end
      end
      ST_CHECK: begin
        entry_d = '0;
        dcnt_d  = 4'd0;
        if (entry_q == code_q) begin
          state_d = ST_OPEN;
          fail_d  = 4'd0;
        end else begin
          fail_d   = fail_inc;
          lo_tmr_d = '0;
          state_d  = (fail_inc >= 4'(MAX_FAILS)) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_OPEN: begin
        if (lock_edge)      state_d = ST_LOCKED;
        else if (prog_edge) state_d = ST_PROGRAM;
      end
      ST_LOCKOUT: begin
        if (lo_tmr_q == LW'(LOCKOUT_TICKS - 1)) begin
          lo_tmr_d = '0;
          fail_d   = 4'd0;
          state_d  = ST_LOCKED;
        end else begin
          lo_tmr_d = lo_tmr_q + LW'(1);
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOCKED;
      entry_q  <= '0;
      code_q   <= DEFAULT_CODE;
      dcnt_q   <= 4'd0;
      fail_q   <= 4'd0;
      lo_tmr_q <= '0;
      lock_s_q <= 3'b000;
      prog_s_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      code_q   <= code_d;
      dcnt_q   <= dcnt_d;
      fail_q   <= fail_d;
      lo_tmr_q <= lo_tmr_d;
      lock_s_q <= {lock_s_q[1:0], bus.lock_btn};
      prog_s_q <= {prog_s_q[1:0], bus.prog_btn};
    end
  end

  assign bus.key_valid   = kv;
  assign bus.key_code    = kc;
  assign bus.digit_count = dcnt_q[2:0];
  assign bus.unlocked    = (state_q == ST_OPEN) || (state_q == ST_PROGRAM);
  assign bus.lockout     = (state_q == ST_LOCKOUT);
  assign bus.fail_count  = fail_q;
  assign bus.state_out   = state_q;

endmodule
